// File: rtl/ysyx_22041071_axi_rd_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22041071_axi_rd_resp_pkg
// Description : Shared constants and types for the AXI4 read responder:
//               bus widths, AXI size encodings, response codes, default
//               memory window and the responder state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_22041071_axi_rd_resp_pkg;

    localparam int c_ADDR_BUS       = 64;
    localparam int c_DATA_BUS       = 64;
    localparam int c_AXI_LEN_WIDTH  = 8;
    localparam int c_ID_WIDTH       = 4;

    // AXI ar_size encodings (log2 of bytes per beat)
    localparam logic [1:0] c_SIZE_B = 2'd0;
    localparam logic [1:0] c_SIZE_H = 2'd1;
    localparam logic [1:0] c_SIZE_W = 2'd2;
    localparam logic [1:0] c_SIZE_D = 2'd3;

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_DECERR = 2'b11;

    localparam logic [63:0] c_MEM_BASE = 64'h0000_0000_8000_0000;
    localparam logic [63:0] c_MEM_SIZE = 64'h0000_0000_0800_0000;

    // REQ drives the SRAM, WAIT captures its data, RESP holds the R beat.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/ysyx_22041071_axi_burst_addr.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22041071_axi_burst_addr
// Description : Beat address generator for INCR read bursts. Holds the
//               current beat address, beat counter, burst length and size;
//               produces the aligned SRAM word address, last-beat flag and
//               memory-window decode for the current beat.
// Ports       : i_load/i_addr/i_len/i_size - start a burst
//               i_advance                  - step to the next beat
//               o_word_addr                - beat address, low 3 bits zero
//               o_in_range                 - beat address inside the window
//               o_is_last                  - current beat is the final one
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22041071_axi_burst_addr
    import ysyx_22041071_axi_rd_resp_pkg::*;
#(
    parameter int                ADDR_W   = c_ADDR_BUS,
    parameter int                LEN_W    = c_AXI_LEN_WIDTH,
    parameter logic [ADDR_W-1:0] MEM_BASE = ADDR_W'(c_MEM_BASE),
    parameter logic [ADDR_W-1:0] MEM_SIZE = ADDR_W'(c_MEM_SIZE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LEN_W-1:0]  i_len,
    input  logic [1:0]        i_size,
    input  logic              i_advance,
    output logic [ADDR_W-1:0] o_word_addr,
    output logic              o_in_range,
    output logic              o_is_last
);

    logic [ADDR_W-1:0] beat_addr_q, beat_addr_d;
    logic [LEN_W-1:0]  beat_cnt_q,  beat_cnt_d;
    logic [LEN_W-1:0]  len_q,       len_d;
    logic [1:0]        size_q,      size_d;

    always_comb begin
        beat_addr_d = beat_addr_q;
        beat_cnt_d  = beat_cnt_q;
        len_d       = len_q;
        size_d      = size_q;
        if (i_load) begin
            beat_addr_d = i_addr;
            beat_cnt_d  = '0;
            len_d       = i_len;
            size_d      = i_size;
        end else if (i_advance) begin
            // Unaligned starts are kept as-is; the add wraps modulo 2^ADDR_W.
            beat_addr_d = beat_addr_q + (ADDR_W'(1) << size_q);
            beat_cnt_d  = beat_cnt_q + LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_addr_q <= '0;
            beat_cnt_q  <= '0;
            len_q       <= '0;
            size_q      <= '0;
        end else begin
            beat_addr_q <= beat_addr_d;
            beat_cnt_q  <= beat_cnt_d;
            len_q       <= len_d;
            size_q      <= size_d;
        end
    end

    // Offset compare avoids overflow of MEM_BASE+MEM_SIZE at the top of the
    // address space; addresses below MEM_BASE wrap to huge offsets.
    assign o_in_range  = (beat_addr_q - MEM_BASE) < MEM_SIZE;
    assign o_is_last   = (beat_cnt_q == len_q);
    assign o_word_addr = {beat_addr_q[ADDR_W-1:3], 3'b000};

endmodule
`default_nettype wire

// File: rtl/ysyx_22041071_axi_rd_resp.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22041071_axi_rd_resp
// Description : AXI4 read-channel slave. Accepts one AR transaction at a
//               time, walks INCR bursts beat by beat against a 1-cycle
//               latency synchronous SRAM and returns each beat on R with
//               rready backpressure. Out-of-window beats return DECERR/0.
// Ports       : ar_*      - read address channel (slave side)
//               r_*       - read data channel (slave side)
//               mem_en/mem_addr/mem_rdata - SRAM read port
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22041071_axi_rd_resp
    import ysyx_22041071_axi_rd_resp_pkg::*;
#(
    parameter int                ADDR_W   = c_ADDR_BUS,
    parameter int                DATA_W   = c_DATA_BUS,
    parameter int                LEN_W    = c_AXI_LEN_WIDTH,
    parameter int                ID_W     = c_ID_WIDTH,
    parameter logic [ADDR_W-1:0] MEM_BASE = ADDR_W'(c_MEM_BASE),
    parameter logic [ADDR_W-1:0] MEM_SIZE = ADDR_W'(c_MEM_SIZE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ar_valid,
    output logic              ar_ready,
    input  logic [ADDR_W-1:0] ar_addr,
    input  logic [LEN_W-1:0]  ar_len,
    input  logic [1:0]        ar_size,
    input  logic [ID_W-1:0]   ar_id,
    output logic              r_valid,
    input  logic              r_ready,
    output logic [DATA_W-1:0] r_data,
    output logic [1:0]        r_resp,
    output logic              r_last,
    output logic [ID_W-1:0]   r_id,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state_q,   state_d;
    logic              r_valid_q, r_valid_d;
    logic              r_last_q,  r_last_d;
    logic [1:0]        r_resp_q,  r_resp_d;
    logic [DATA_W-1:0] r_data_q,  r_data_d;
    logic [ID_W-1:0]   r_id_q,    r_id_d;
    logic [ID_W-1:0]   id_q,      id_d;

    logic              w_ar_fire;
    logic              w_advance;
    logic              w_in_range;
    logic              w_is_last;
    logic [ADDR_W-1:0] w_word_addr;

    assign ar_ready  = (state_q == S_IDLE) && !reset;
    assign w_ar_fire = ar_valid && ar_ready;
    // Step to the next beat only when a non-final beat is accepted.
    assign w_advance = (state_q == S_RESP) && r_ready && !r_last_q;

    ysyx_22041071_axi_burst_addr #(
        .ADDR_W   (ADDR_W),
        .LEN_W    (LEN_W),
        .MEM_BASE (MEM_BASE),
        .MEM_SIZE (MEM_SIZE)
    ) u_burst_addr (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_ar_fire),
        .i_addr      (ar_addr),
        .i_len       (ar_len),
        .i_size      (ar_size),
        .i_advance   (w_advance),
        .o_word_addr (w_word_addr),
        .o_in_range  (w_in_range),
        .o_is_last   (w_is_last)
    );

    always_comb begin
        state_d   = state_q;
        r_valid_d = r_valid_q;
        r_last_d  = r_last_q;
        r_resp_d  = r_resp_q;
        r_data_d  = r_data_q;
        r_id_d    = r_id_q;
        id_d      = id_q;
        case (state_q)
            S_IDLE: begin
                if (w_ar_fire) begin
                    id_d    = ar_id;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // SRAM data for the REQ issued last cycle is valid now.
                r_data_d  = w_in_range ? mem_rdata : '0;
                r_resp_d  = w_in_range ? c_RESP_OKAY : c_RESP_DECERR;
                r_last_d  = w_is_last;
                r_id_d    = id_q;
                r_valid_d = 1'b1;
                state_d   = S_RESP;
            end
            S_RESP: begin
                if (r_ready) begin
                    r_valid_d = 1'b0;
                    state_d   = r_last_q ? S_IDLE : S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            r_valid_q <= 1'b0;
            r_last_q  <= 1'b0;
            r_resp_q  <= 2'b00;
            r_data_q  <= '0;
            r_id_q    <= '0;
            id_q      <= '0;
        end else begin
            state_q   <= state_d;
            r_valid_q <= r_valid_d;
            r_last_q  <= r_last_d;
            r_resp_q  <= r_resp_d;
            r_data_q  <= r_data_d;
            r_id_q    <= r_id_d;
            id_q      <= id_d;
        end
    end

    assign r_valid  = r_valid_q;
    assign r_last   = r_last_q;
    assign r_resp   = r_resp_q;
    assign r_data   = r_data_q;
    assign r_id     = r_id_q;
    assign mem_en   = (state_q == S_REQ) && w_in_range && !reset;
    assign mem_addr = w_word_addr;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22041071_axi_rd_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_22041071_axi_rd_resp
// Description : Self-checking bench for the AXI4 read responder. Directed
//               scenarios plus randomized bursts are compared against a
//               beat-list reference model (start + k*2^size, window decode,
//               hashed SRAM contents).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22041071_axi_rd_resp;

    localparam logic [63:0] c_BASE = 64'h0000_0000_8000_0000;
    localparam logic [63:0] c_SIZE = 64'h0000_0000_0800_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ar_valid = 1'b0;
    logic        ar_ready;
    logic [63:0] ar_addr = '0;
    logic [7:0]  ar_len = '0;
    logic [1:0]  ar_size = '0;
    logic [3:0]  ar_id = '0;
    logic        r_valid;
    logic        r_ready = 1'b0;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic [3:0]  r_id;
    logic        mem_en;
    logic [63:0] mem_addr;
    logic [63:0] mem_rdata = '0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ysyx_22041071_axi_rd_resp dut (
        .clk       (clk),
        .reset     (rst),
        .ar_valid  (ar_valid),
        .ar_ready  (ar_ready),
        .ar_addr   (ar_addr),
        .ar_len    (ar_len),
        .ar_size   (ar_size),
        .ar_id     (ar_id),
        .r_valid   (r_valid),
        .r_ready   (r_ready),
        .r_data    (r_data),
        .r_resp    (r_resp),
        .r_last    (r_last),
        .r_id      (r_id),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    // ---------------- reference model ----------------
    function automatic logic [63:0] mem_word(input logic [63:0] wa);
        if (wa == 64'h0000_0000_8000_0000) return 64'h1122_3344_5566_7788;
        return (wa * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0F1E_2D3C_4B5A_6978;
    endfunction

    function automatic bit in_window(input logic [63:0] a);
        logic [64:0] a65;
        a65 = {1'b0, a};
        return (a65 >= {1'b0, c_BASE}) && (a65 < ({1'b0, c_BASE} + {1'b0, c_SIZE}));
    endfunction

    function automatic logic [63:0] beat_addr(input logic [63:0] start, input int k, input int size);
        return start + (64'(k) << size);
    endfunction

    // SRAM: data valid only the cycle after mem_en, junk otherwise.
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= mem_word(mem_addr);
        else        mem_rdata <= 64'hBAD0_BAD0_BAD0_BAD0;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue an AR; returns just after the handshake edge (DUT in REQ).
    task automatic issue_ar(input logic [63:0] addr, input int len, input int size, input logic [3:0] id);
        ar_valid = 1'b1;
        ar_addr  = addr;
        ar_len   = 8'(len);
        ar_size  = 2'(size);
        ar_id    = id;
        check("ar_ready_idle", 64'(ar_ready), 64'd1);
        tick();
        ar_valid = 1'b0;
        check("ar_ready_busy", 64'(ar_ready), 64'd0);
    endtask

    // Called just after the edge that started beat k (AR or prior R handshake).
    // Checks the SRAM request, latency, beat contents, hold under stall.
    task automatic run_beat(input logic [63:0] start, input int k, input int len, input int size,
                            input logic [3:0] id, input int stall);
        logic [63:0] a, wa, exp_data;
        bit          en;
        int          n;
        a        = beat_addr(start, k, size);
        wa       = {a[63:3], 3'b000};
        en       = in_window(a);
        exp_data = en ? mem_word(wa) : 64'd0;
        check("mem_en", 64'(mem_en), 64'(en));
        if (en) check("mem_addr", mem_addr, wa);
        n = 0;
        while (!r_valid && n < 8) begin
            tick();
            n++;
        end
        check("beat_latency", 64'(n), 64'd2);
        check("r_data", r_data, exp_data);
        check("r_resp", 64'(r_resp), en ? 64'd0 : 64'd3);
        check("r_last", 64'(r_last), 64'(k == len));
        check("r_id", 64'(r_id), 64'(id));
        for (int s = 0; s < stall; s++) begin
            tick();
            check("hold_valid", 64'(r_valid), 64'd1);
            check("hold_data", r_data, exp_data);
            check("hold_last", 64'(r_last), 64'(k == len));
            check("stall_no_mem_en", 64'(mem_en), 64'd0);
        end
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
        check("valid_drop", 64'(r_valid), 64'd0);
    endtask

    task automatic do_txn(input logic [63:0] addr, input int len, input int size, input logic [3:0] id,
                          input int stall_beat, input int stall_cycles, input bit rnd_stall);
        int s;
        issue_ar(addr, len, size, id);
        for (int k = 0; k <= len; k++) begin
            s = (k == stall_beat) ? stall_cycles : (rnd_stall ? int'($urandom_range(0, 2)) : 0);
            run_beat(addr, k, len, size, id, s);
        end
        check("ar_ready_after", 64'(ar_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] a;
        int          len, size;
        // ---------------- reset ----------------
        tick(); tick(); tick();
        check("rst_ar_ready", 64'(ar_ready), 64'd0);
        check("rst_r_valid", 64'(r_valid), 64'd0);
        check("rst_r_last", 64'(r_last), 64'd0);
        check("rst_r_resp", 64'(r_resp), 64'd0);
        check("rst_r_data", r_data, 64'd0);
        check("rst_r_id", 64'(r_id), 64'd0);
        check("rst_mem_en", 64'(mem_en), 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        rst = 1'b0;
        tick();
        check("ar_ready_post_rst", 64'(ar_ready), 64'd1);

        // single beat, burst, backpressure, decode error, window crossing, wrap
        do_txn(64'h0000_0000_8000_0000, 0, 3, 4'd5, -1, 0, 1'b0);
        do_txn(64'h0000_0000_8000_0010, 3, 3, 4'd2, -1, 0, 1'b0);
        do_txn(64'h0000_0000_8000_0200, 1, 3, 4'd9, 0, 5, 1'b0);
        do_txn(64'h0000_0000_3000_0000, 0, 3, 4'd1, -1, 0, 1'b0);
        do_txn(64'h0000_0000_87FF_FFF8, 1, 3, 4'd7, -1, 0, 1'b0);
        do_txn(64'hFFFF_FFFF_FFFF_FFF8, 1, 3, 4'd3, -1, 0, 1'b0);
        do_txn(64'h0000_0000_8000_0003, 4, 1, 4'd6, 2, 2, 1'b0);

        // reset during RESP of beat 1 of a 4-beat burst
        issue_ar(64'h0000_0000_8000_0100, 3, 3, 4'd4);
        run_beat(64'h0000_0000_8000_0100, 0, 3, 3, 4'd4, 0);
        tick(); tick();
        check("mid_valid_beat1", 64'(r_valid), 64'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_r_valid", 64'(r_valid), 64'd0);
        check("mid_rst_ar_ready", 64'(ar_ready), 64'd0);
        rst = 1'b0;
        tick();
        check("mid_ar_ready_after", 64'(ar_ready), 64'd1);
        r_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("no_stale_valid", 64'(r_valid), 64'd0);
            check("no_stale_mem_en", 64'(mem_en), 64'd0);
        end
        r_ready = 1'b0;

        // longest burst: 256 beats
        do_txn(64'h0000_0000_8000_1000, 255, 3, 4'd15, -1, 0, 1'b0);

        // randomized bursts
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 3))
                0:       a = c_BASE + 64'($urandom_range(0, 4095));
                1:       a = c_BASE + c_SIZE - 64'($urandom_range(1, 64));
                2:       a = c_BASE - 64'($urandom_range(1, 64));
                default: a = {$urandom, $urandom};
            endcase
            len  = int'($urandom_range(0, 7));
            size = int'($urandom_range(0, 3));
            do_txn(a, len, size, 4'($urandom), -1, 0, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/ysyx_22041071_axi_rd_resp.md
Name: ysyx_22041071_axi_rd_resp

Overview:
- AXI4 read-channel responder (slave) that answers the core's instruction/data fetch read-address requests.
- Accepts one AR transaction at a time and walks INCR bursts beat by beat.
- Reads a synchronous single-port SRAM with 1-cycle read latency.
- Returns each beat on the R channel and honours rready backpressure.
- Sits between the CPU-side AXI read master and the main-memory SRAM model.

Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width (one 8-byte word per beat)
- LEN_W, 8, ar_len width (beats = ar_len+1)
- ID_W, 4, transaction ID width
- MEM_BASE, 64'h0000_0000_8000_0000, first decoded address
- MEM_SIZE, 64'h0000_0000_0800_0000, decoded window size in bytes

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ar_valid  in  1  read-address valid
- ar_ready  out  1  read-address ready
- ar_addr  in  ADDR_W  burst start address
- ar_len  in  LEN_W  beats minus one
- ar_size  in  2  log2 bytes per beat (0..3)
- ar_id  in  ID_W  transaction ID
- r_valid  out  1  read-data valid
- r_ready  in  1  read-data ready
- r_data  out  DATA_W  beat data
- r_resp  out  2  2'b00 OKAY, 2'b11 DECERR
- r_last  out  1  final beat of burst
- r_id  out  ID_W  echoed ar_id
- mem_en  out  1  SRAM read enable
- mem_addr  out  ADDR_W  SRAM word address, low 3 bits zero
- mem_rdata  in  DATA_W  SRAM data, valid the cycle after mem_en

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous and active-high.
  - Reset forces state IDLE and clears beat counter, captured address and ID.
  - Reset values: r_valid=0, r_last=0, r_resp=0, r_data=0, r_id=0, mem_en=0, mem_addr=0.
  - ar_ready=0 while reset is high.
  - Reset mid-burst abandons the burst; no further R beats are issued.
- State machine: IDLE, REQ, WAIT, RESP.
- IDLE:
  - ar_ready=1 (combinational: state==IDLE && !reset).
  - On ar_valid&&ar_ready, capture addr, len, size, id; clear beat_cnt; go to REQ.
- REQ:
  - Decode the current beat address: in range iff MEM_BASE <= beat_addr < MEM_BASE+MEM_SIZE.
  - In range: mem_en=1, mem_addr={beat_addr[63:3],3'b000}.
  - Out of range: mem_en=0.
  - Go to WAIT.
- WAIT:
  - Register r_data<=mem_rdata (or 0 if out of range).
  - r_resp<=OKAY or DECERR; r_last<=(beat_cnt==len); r_id<=captured id; r_valid<=1.
  - Go to RESP.
- RESP:
  - Hold r_valid and all R outputs stable until r_ready.
  - On handshake with last set: r_valid<=0, go to IDLE.
  - On handshake without last: r_valid<=0, beat_addr+=(1<<size), beat_cnt+=1, go to REQ.
- Latency: AR handshake at edge T gives mem_en in cycle T+1 and first r_valid in cycle T+3. Subsequent beats arrive 3 cycles after the previous R handshake.
- Only one outstanding transaction; ar_ready=0 outside IDLE.
- Address arithmetic:
  - Modulo 2^ADDR_W; an increment wrapping past all-ones wraps to 0.
  - Decode is per beat: a burst crossing the window edge returns OKAY beats, then DECERR beats.
  - An unaligned start address is not realigned for the increment.
- ar_size=3 with len=255 gives 256 beats; beat_cnt is LEN_W bits and never overflows.
- No lane masking: the full 64-bit word is returned; the master selects bytes.

Decomposition:
- Shared define.v holds:
  - ysyx_22041071_ADDR_BUS and ysyx_22041071_AXI_LEN_WIDTH
  - ysyx_22041071_SIZE_B/H/W/D
  - new resp codes ysyx_22041071_RESP_OKAY / ysyx_22041071_RESP_DECERR
  - MEM_BASE/MEM_SIZE defaults
- One natural sub-module: ysyx_22041071_axi_burst_addr. It holds beat_addr, beat_cnt, increment, last detection and range decode. The FSM stays in the top.

Test Plan:
- Single beat:
  - Stimulus: ar_addr=0x8000_0000, len=0, size=3, id=5, r_ready=1, SRAM word = 0x1122_3344_5566_7788.
  - Required: mem_en at T+1 with mem_addr=0x8000_0000; r_valid at T+3 with r_data=0x1122_3344_5566_7788, r_last=1, r_resp=0, r_id=5; ar_ready high again the next cycle.
- Burst:
  - Stimulus: ar_addr=0x8000_0010, len=3, size=3.
  - Required: mem_addr sequence 0x...10, 0x...18, 0x...20, 0x...28; four beats, r_last only on the fourth.
- Backpressure:
  - Stimulus: r_ready=0 for 5 cycles on beat 0 of a len=1 burst.
  - Required: r_valid, r_data and r_last stay stable, no mem_en issued for beat 1; beat 1 arrives 3 cycles after r_ready rises.
- Decode error:
  - Stimulus: ar_addr=0x0000_0000_3000_0000, len=0.
  - Required: mem_en never asserted; r_resp=2'b11, r_data=0, r_last=1.
- Window crossing:
  - Stimulus: ar_addr=0x87FF_FFF8, len=1, size=3.
  - Required: beat 0 OKAY, beat 1 DECERR.
- Reset mid-burst:
  - Stimulus: assert reset during RESP of beat 1 of a len=3 burst.
  - Required: r_valid=0 the next cycle; ar_ready=1 the cycle after reset drops; no stale beats.
